// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle handshake and imem write-port bundle for instr_encoder.
// master = front end that supplies decoded fields and watches the imem port,
// slave  = the encoder itself.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              err;

    modport master (
        output in_valid, fmt, op, rd, rs1, rs2, funct3, funct7, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, err
    );

    modport slave (
        input  in_valid, fmt, op, rd, rs1, rs2, funct3, funct7, imm,
        output in_ready, mem_we, mem_addr, mem_wdata, count, err
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit instruction words and
// writes them into imem at an auto-incrementing word address.
// Optional macro ENCODER_IMM_CHECK_EN: reject bundles whose immediate does not
// fit the selected format; when undefined, immediates are silently truncated.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    instr_encoder_if.slave    bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [31:0]       wdata, wdata_nxt;
    logic              err, err_nxt;

    logic              accept;
    logic [31:0]       word;
    logic              fmt_ok;
    logic              imm_ok;
    logic              legal;

    // Format-dependent bit packing of the field bundle
    always_comb begin
        word = 32'd0;
        case (bus.fmt)
            FMT_R: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.op};
            FMT_I: word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.op};
            FMT_S: word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.op};
            FMT_B: word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:1], bus.imm[11], bus.op};
            FMT_U: word = {bus.imm[31:12], bus.rd, bus.op};
            FMT_J: word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                           bus.rd, bus.op};
            default: word = 32'd0;
        endcase
    end

    // Bundle legality: known format, 32-bit opcode space, optional immediate range
    always_comb begin
        fmt_ok = (bus.fmt != 3'b110) && (bus.fmt != 3'b111);
        imm_ok = 1'b1;
`ifdef ENCODER_IMM_CHECK_EN
        case (bus.fmt)
            FMT_I, FMT_S: imm_ok = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
            FMT_B:        imm_ok = ((&bus.imm[31:12]) || !(|bus.imm[31:12])) && !bus.imm[0];
            FMT_J:        imm_ok = ((&bus.imm[31:20]) || !(|bus.imm[31:20])) && !bus.imm[0];
            FMT_U:        imm_ok = (bus.imm[11:0] == 12'd0);
            default:      imm_ok = 1'b1;
        endcase
`endif
        legal = fmt_ok && (bus.op[1:0] == 2'b11) && imm_ok;
    end

    // Next-state and next-register values; clear outranks the handshake
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        count_nxt = count;
        wdata_nxt = wdata;
        err_nxt   = err;
        accept    = (state == ST_IDLE) && !reset;
        if (clear) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = '0;
            count_nxt = '0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && accept) begin
                        if (legal) begin
                            wdata_nxt = word;
                            state_nxt = ST_WRITE;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    count_nxt = count + CNT_W'(1);
                    if (ptr == PTR_MAX) begin
                        state_nxt = ST_FULL;
                    end else begin
                        ptr_nxt   = ptr + ADDR_W'(1);
                        state_nxt = ST_IDLE;
                    end
                end
                ST_FULL: state_nxt = ST_FULL;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            count <= '0;
            wdata <= 32'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            count <= count_nxt;
            wdata <= wdata_nxt;
            err   <= err_nxt;
        end
    end

    assign bus.in_ready  = accept;
    assign bus.mem_we    = (state == ST_WRITE) && !clear;
    assign bus.mem_addr  = ptr;
    assign bus.mem_wdata = wdata;
    assign bus.count     = count;
    assign bus.err       = err;
endmodule
